// File: rtl/lcd_bus_receiver_pkg.sv
// Shared definitions for the LCD bus receiver: FSM states, opcode classes, blank code.
// Used by lcd_bus_receiver (optional LCD_ERR_EN error flag) and lcd_shadow_ram.
package lcd_bus_receiver_pkg;

  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int         RAM_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_RESET_CLR,
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISP,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } op_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } bus_t;

  // Instruction class is chosen by the highest set bit of the byte.
  function automatic op_e decode_op(input logic [7:0] ins);
    if (ins[7])      return OP_DDRAM;
    else if (ins[6]) return OP_CGRAM;
    else if (ins[5]) return OP_FUNC;
    else if (ins[4]) return OP_SHIFT;
    else if (ins[3]) return OP_DISP;
    else if (ins[2]) return OP_ENTRY;
    else if (ins[1]) return OP_HOME;
    else if (ins[0]) return OP_CLEAR;
    else             return OP_NOP;
  endfunction

  // {row, col} is a flat 5-bit index, so plain modulo-32 stepping gives the row wrap.
  function automatic logic [4:0] step_addr(input logic [4:0] addr, input logic up);
    return up ? addr + 5'd1 : addr - 5'd1;
  endfunction

endpackage

// File: rtl/lcd_shadow_ram.sv
// 32x8 shadow of the LCD character RAM: one synchronous write port, one registered read port.
// Array contents are not reset; the controller's clear sweep initialises them.
module lcd_shadow_ram
  import lcd_bus_receiver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style write-bus responder: synchronizers, E falling-edge detect, decoder, cursor, FSM.
// Define LCD_ERR_EN to build the sticky protocol error flag; otherwise err is tied low.
module lcd_bus_receiver
  import lcd_bus_receiver_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       busy,
  output logic       err
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES);

  logic [SYNC_STAGES-1:0] e_sync;
  bus_t                   bus_sync [SYNC_STAGES];
  logic                   e_prev;
  bus_t                   bus_prev;
  logic                   fall;

  state_e                 state;
  bus_t                   txn;
  logic                   incr;
  logic [CNT_W-1:0]       clr_cnt;

  logic                   ram_we;
  logic [4:0]             ram_addr;
  logic [7:0]             ram_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_sync   <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) bus_sync[i] <= '0;
      e_prev   <= 1'b0;
      bus_prev <= '0;
    end else begin
      e_sync      <= {e_sync[SYNC_STAGES-2:0], lcd_e};
      bus_sync[0] <= '{rs: lcd_rs, rw: lcd_rw, data: lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) bus_sync[i] <= bus_sync[i-1];
      // Fields are delayed one more stage so they line up with e_prev.
      e_prev   <= e_sync[SYNC_STAGES-1];
      bus_prev <= bus_sync[SYNC_STAGES-1];
    end
  end

  assign fall = e_prev & ~e_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RESET_CLR;
      busy        <= 1'b1;
      clr_cnt     <= CNT_W'(CLEAR_CYCLES - 1);
      txn         <= '0;
      cursor_addr <= '0;
      incr        <= 1'b1;
      display_on  <= 1'b0;
    end else begin
      case (state)
        ST_RESET_CLR, ST_CLEAR: begin
          if (clr_cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt - CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (fall) begin
            txn   <= bus_prev;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          if (!txn.rw) begin
            if (txn.rs) begin
              cursor_addr <= step_addr(cursor_addr, incr);
            end else begin
              case (decode_op(txn.data))
                OP_CLEAR: begin
                  cursor_addr <= '0;
                  incr        <= 1'b1;
                  busy        <= 1'b1;
                  clr_cnt     <= CNT_W'(CLEAR_CYCLES - 1);
                  state       <= ST_CLEAR;
                end
                OP_HOME:  cursor_addr <= '0;
                OP_ENTRY: incr <= txn.data[1];
                OP_DISP:  display_on <= txn.data[2];
                OP_SHIFT: if (!txn.data[3]) cursor_addr <= step_addr(cursor_addr, txn.data[2]);
                OP_DDRAM: if (txn.data[5:4] == 2'b00) cursor_addr <= {txn.data[6], txn.data[3:0]};
                default:  ;
              endcase
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The sweep owns the write port while busy; otherwise only data writes reach it.
  assign ram_we    = busy | ((state == ST_EXEC) & txn.rs & ~txn.rw);
  assign ram_addr  = busy ? clr_cnt[4:0] : cursor_addr;
  assign ram_wdata = busy ? BLANK_CHAR : txn.data;

  lcd_shadow_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (ram_addr),
    .wr_data (ram_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_char)
  );

`ifdef LCD_ERR_EN
  logic bad_txn;

  assign bad_txn = (busy & fall) |
                   ((state == ST_EXEC) &
                    (txn.rw | (~txn.rs & txn.data[7] & (txn.data[5:4] != 2'b00))));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (bad_txn) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
